// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the IF/MEM requesters, the port arbiter and the memory model.
// Handshake: a requester holds *_req with stable fields until its one-cycle *_done;
// the arbiter holds mem_req with stable mem_* fields until it samples mem_ack high.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_done;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_done;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    logic              pipe_stall;

    // Arbiter side
    modport master (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
        output if_done, if_rdata, d_done, d_rdata, mem_req, mem_we, mem_addr, mem_wdata,
        output pipe_stall
    );

    // Requester and memory side
    modport slave (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
        input  if_done, if_rdata, d_done, d_rdata, mem_req, mem_we, mem_addr, mem_wdata,
        input  pipe_stall
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store, with a
// starvation guard for fetch and a combinational pipeline freeze.
module mem_port_arbiter #(
    parameter  int ADDR_W     = 32,
    parameter  int DATA_W     = 32,
    parameter  int STARVE_MAX = 4,
    localparam int CNT_W      = $clog2(STARVE_MAX + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_port_arbiter_if.master   bus,
    output logic [1:0]           dbg_state,
    output logic [CNT_W-1:0]     starve_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state;
    logic   starve_full;

    assign starve_full = (starve_cnt == CNT_W'(STARVE_MAX));
    assign dbg_state   = state;

    // Freeze holds while a request is pending and released in its done cycle.
    assign bus.pipe_stall = rst & ((bus.if_req & ~bus.if_done) | (bus.d_req & ~bus.d_done));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            starve_cnt    <= '0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= ADDR_W'(0);
            bus.mem_wdata <= DATA_W'(0);
            bus.if_done   <= 1'b0;
            bus.d_done    <= 1'b0;
            bus.if_rdata  <= DATA_W'(0);
            bus.d_rdata   <= DATA_W'(0);
        end else begin
            case (state)
                IDLE: begin
                    // Data wins ties unless fetch has already lost STARVE_MAX times in a row.
                    if (bus.d_req && !(bus.if_req && starve_full)) begin
                        state         <= GNT_D;
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= bus.d_we;
                        bus.mem_addr  <= bus.d_addr;
                        bus.mem_wdata <= bus.d_wdata;
                        if (!bus.if_req) begin
                            starve_cnt <= '0;
                        end else if (!starve_full) begin
                            starve_cnt <= starve_cnt + CNT_W'(1);
                        end
                    end else if (bus.if_req) begin
                        state         <= GNT_I;
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= 1'b0;
                        bus.mem_addr  <= bus.if_addr;
                        bus.mem_wdata <= DATA_W'(0);
                        starve_cnt    <= '0;
                    end else begin
                        starve_cnt <= '0;
                    end
                end
                GNT_I, GNT_D: begin
                    if (bus.mem_ack) begin
                        state       <= RESP;
                        bus.mem_req <= 1'b0;
                        bus.mem_we  <= 1'b0;
                        if (state == GNT_I) begin
                            bus.if_done  <= 1'b1;
                            bus.if_rdata <= bus.mem_rdata;
                        end else begin
                            bus.d_done <= 1'b1;
                            if (!bus.mem_we) begin
                                bus.d_rdata <= bus.mem_rdata;
                            end
                        end
                    end
                end
                RESP: begin
                    state       <= IDLE;
                    bus.if_done <= 1'b0;
                    bus.d_done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed timing cases, then two random requesters
// against a responder with random wait states, scored by a transaction-level model.
module tb_mem_port_arbiter;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 4;
    localparam int CNT_W      = $clog2(STARVE_MAX + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GNT_I = 2'd1;
    localparam logic [1:0] S_GNT_D = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
    logic [1:0]       dbg_state;
    logic [CNT_W-1:0] starve_cnt;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .dbg_state  (dbg_state),
        .starve_cnt (starve_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(string tag, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // ---------------- memory contents ----------------
    logic [31:0] env_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    function automatic logic [31:0] init_word(logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] env_read(logic [31:0] a);
        return env_mem.exists(a) ? env_mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] ref_read(logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] rand_addr();
        return 32'h100 + (32'($urandom_range(0, 15)) << 2);
    endfunction

    // ---------------- memory responder ----------------
    int   fixed_wait = 0;
    logic ack_force  = 1'b0;
    int   wait_left  = -1;

    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = $urandom();
            if (!rst) wait_left = -1;
            if (ack_force) begin
                bus.mem_ack = 1'b1;
            end else if (rst && bus.mem_req) begin
                if (wait_left < 0) wait_left = (fixed_wait >= 0) ? fixed_wait : $urandom_range(0, 3);
                if (wait_left == 0) begin
                    bus.mem_ack = 1'b1;
                    if (bus.mem_we) env_mem[bus.mem_addr] = bus.mem_wdata;
                    else bus.mem_rdata = env_read(bus.mem_addr);
                    wait_left = -1;
                end else begin
                    wait_left--;
                end
            end
        end
    end

    // ---------------- scoreboard / reference model ----------------
    logic [DATA_W-1:0] exp_q[$];
    logic        p_if_req = 0, p_d_req = 0, p_d_we = 0, p_mem_req = 0;
    logic [31:0] p_if_addr = 0, p_d_addr = 0, p_d_wdata = 0;
    int          cur_port = 0, ack_port = 0, exp_port = 0, starve_m = 0;
    logic        cur_we = 0, ack_we = 0;
    logic [31:0] cur_addr = 0, cur_wdata = 0, last_if = 0, last_d = 0;

    always @(negedge clk) begin
        if (!rst) begin
            check_eq("reset_ctrl", {bus.mem_req, bus.mem_we, bus.if_done, bus.d_done,
                                    bus.pipe_stall, dbg_state, starve_cnt}, 64'd0);
            check_eq("reset_mem_bus", {bus.mem_addr, bus.mem_wdata}, 64'd0);
            check_eq("reset_rdata", {bus.if_rdata, bus.d_rdata}, 64'd0);
            exp_q.delete();
            starve_m  = 0;
            cur_port  = 0;
            ack_port  = 0;
            last_if   = 0;
            last_d    = 0;
            p_mem_req = 0;
            p_if_req  = 0;
            p_d_req   = 0;
        end else begin
            // completion one cycle after the ack
            check_eq("if_done", bus.if_done, ack_port == 1);
            check_eq("d_done", bus.d_done, ack_port == 2);
            if (ack_port == 1 && exp_q.size() > 0) last_if = exp_q.pop_front();
            if (ack_port == 2 && !ack_we && exp_q.size() > 0) last_d = exp_q.pop_front();
            check_eq("if_rdata", bus.if_rdata, last_if);
            check_eq("d_rdata", bus.d_rdata, last_d);
            if (ack_port != 0) begin
                check_eq("resp_state", dbg_state, S_RESP);
                check_eq("resp_mem_req", bus.mem_req, 0);
                cur_port = 0;
            end

            // a new grant is decided from the requests of the previous cycle
            if (bus.mem_req && !p_mem_req) begin
                if (p_d_req && !(p_if_req && starve_m == STARVE_MAX)) exp_port = 2;
                else if (p_if_req) exp_port = 1;
                else exp_port = 0;
                check_eq("grant_state", dbg_state,
                         (exp_port == 1) ? S_GNT_I : (exp_port == 2) ? S_GNT_D : S_IDLE);
                if (exp_port == 1) begin
                    starve_m  = 0;
                    cur_addr  = p_if_addr;
                    cur_we    = 0;
                    cur_wdata = 0;
                end else if (exp_port == 2) begin
                    if (p_if_req && starve_m < STARVE_MAX) starve_m++;
                    cur_addr  = p_d_addr;
                    cur_we    = p_d_we;
                    cur_wdata = p_d_wdata;
                end
                cur_port = exp_port;
                if (exp_port != 0) begin
                    if (cur_we) ref_mem[cur_addr] = cur_wdata;
                    else exp_q.push_back(ref_read(cur_addr));
                end
                check_eq("starve_cnt", starve_cnt, starve_m);
            end

            if (bus.mem_req) begin
                check_eq("mem_addr", bus.mem_addr, cur_addr);
                check_eq("mem_we", bus.mem_we, cur_we);
                if (cur_we) check_eq("mem_wdata", bus.mem_wdata, cur_wdata);
            end else begin
                check_eq("idle_mem_we", bus.mem_we, 0);
            end
            ack_port = (bus.mem_req && bus.mem_ack) ? cur_port : 0;
            ack_we   = cur_we;

            check_eq("pipe_stall", bus.pipe_stall,
                     (bus.if_req && !bus.if_done) || (bus.d_req && !bus.d_done));

            p_if_req  = bus.if_req;
            p_if_addr = bus.if_addr;
            p_d_req   = bus.d_req;
            p_d_we    = bus.d_we;
            p_d_addr  = bus.d_addr;
            p_d_wdata = bus.d_wdata;
            p_mem_req = bus.mem_req;
        end
    end

    // ---------------- random requester drivers ----------------
    task automatic if_agent(int n);
        bit got;
        int gap;
        for (int i = 0; i < n; i++) begin
            bus.if_req  = 1'b1;
            bus.if_addr = rand_addr();
            got = 0;
            for (int t = 0; t < 300 && !got; t++) begin
                @(negedge clk);
                if (bus.if_done) got = 1;
                else begin
                    cyc();
                    if (cur_port == 1 && bus.mem_req) bus.if_addr = $urandom();
                end
            end
            if (!got) check_eq("if_timeout", 0, 1);
            cyc();
            gap = $urandom_range(0, 2);
            if (gap > 0) begin
                bus.if_req = 1'b0;
                repeat (gap) cyc();
            end
        end
        bus.if_req = 1'b0;
    endtask

    task automatic d_agent(int n);
        bit got;
        int gap;
        for (int i = 0; i < n; i++) begin
            bus.d_req   = 1'b1;
            bus.d_we    = 1'($urandom_range(0, 1));
            bus.d_addr  = rand_addr();
            bus.d_wdata = $urandom();
            got = 0;
            for (int t = 0; t < 300 && !got; t++) begin
                @(negedge clk);
                if (bus.d_done) got = 1;
                else begin
                    cyc();
                    if (cur_port == 2 && bus.mem_req) begin
                        bus.d_addr  = $urandom();
                        bus.d_wdata = $urandom();
                        bus.d_we    = ~bus.d_we;
                    end
                end
            end
            if (!got) check_eq("d_timeout", 0, 1);
            cyc();
            gap = $urandom_range(0, 2);
            if (gap > 0) begin
                bus.d_req = 1'b0;
                repeat (gap) cyc();
            end
        end
        bus.d_req = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] saved;
        logic        prev_req, if_seen, got;
        int          g;

        rst         = 1'b0;
        bus.if_req  = 1'b0;
        bus.if_addr = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        env_mem[32'h10] = 32'h8C01_0004;
        ref_mem[32'h10] = 32'h8C01_0004;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;

        // single zero-wait fetch
        cyc();
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h10;
        @(negedge clk);
        check_eq("t1_stall_c0", bus.pipe_stall, 1);
        cyc();
        @(negedge clk);
        check_eq("t1_mem_req_c1", bus.mem_req, 1);
        check_eq("t1_mem_addr_c1", bus.mem_addr, 32'h10);
        check_eq("t1_mem_we_c1", bus.mem_we, 0);
        check_eq("t1_stall_c1", bus.pipe_stall, 1);
        cyc();
        @(negedge clk);
        check_eq("t1_if_done_c2", bus.if_done, 1);
        check_eq("t1_if_rdata_c2", bus.if_rdata, 32'h8C01_0004);
        check_eq("t1_stall_c2", bus.pipe_stall, 0);
        cyc();
        bus.if_req = 1'b0;
        @(negedge clk);
        check_eq("t1_idle_c3", dbg_state, S_IDLE);

        // simultaneous fetch and load: data first
        cyc();
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h10;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_addr  = 32'h100;
        cyc();
        @(negedge clk);
        check_eq("t2_mem_addr_c1", bus.mem_addr, 32'h100);
        cyc();
        @(negedge clk);
        check_eq("t2_d_done_c2", bus.d_done, 1);
        check_eq("t2_d_rdata_c2", bus.d_rdata, init_word(32'h100));
        cyc();
        bus.d_req = 1'b0;
        cyc();
        @(negedge clk);
        check_eq("t2_mem_addr_c4", bus.mem_addr, 32'h10);
        check_eq("t2_mem_req_c4", bus.mem_req, 1);
        cyc();
        @(negedge clk);
        check_eq("t2_if_done_c5", bus.if_done, 1);
        cyc();
        bus.if_req = 1'b0;

        // store with three wait states, requester fields change after the grant
        cyc();
        fixed_wait  = 3;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h20;
        bus.d_wdata = 32'hDEAD_BEEF;
        cyc();
        bus.d_addr  = 32'h44;
        bus.d_wdata = 32'h0;
        bus.d_we    = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_eq("t3_mem_req", bus.mem_req, 1);
            check_eq("t3_mem_addr", bus.mem_addr, 32'h20);
            check_eq("t3_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
            check_eq("t3_mem_we", bus.mem_we, 1);
            check_eq("t3_no_done", bus.d_done, 0);
            cyc();
        end
        @(negedge clk);
        check_eq("t3_d_done", bus.d_done, 1);
        check_eq("t3_d_rdata_kept", bus.d_rdata, init_word(32'h100));
        cyc();
        bus.d_req  = 1'b0;
        fixed_wait = 0;

        // starvation guard: data x4, fetch, data
        cyc();
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_addr  = 32'h200;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h10;
        prev_req = 0;
        g = 0;
        for (int t = 0; t < 80 && g < 6; t++) begin
            @(negedge clk);
            if (bus.mem_req && !prev_req) begin
                check_eq("t4_grant_addr", bus.mem_addr, (g == 4) ? 32'h10 : 32'h200);
                if (g == 4) check_eq("t4_starve_clear", starve_cnt, 0);
                g++;
            end
            prev_req = bus.mem_req;
            if_seen  = bus.if_done;
            cyc();
            if (if_seen) bus.if_req = 1'b0;
        end
        check_eq("t4_grant_count", g, 6);
        got = 0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            got = bus.d_done;
            cyc();
        end
        check_eq("t4_drain", got, 1);
        bus.d_req = 1'b0;

        // reset in the middle of a data access, ack during and after reset
        cyc();
        fixed_wait  = 10;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_addr  = 32'h30;
        cyc();
        #2;
        check_eq("t5_pre_mem_req", bus.mem_req, 1);
        rst = 1'b0;
        #1;
        check_eq("t5_async_ctrl", {bus.mem_req, bus.mem_we, bus.if_done, bus.d_done,
                                   bus.pipe_stall, dbg_state}, 64'd0);
        check_eq("t5_async_bus", {bus.mem_addr, bus.mem_wdata}, 64'd0);
        check_eq("t5_async_rdata", {bus.if_rdata, bus.d_rdata}, 64'd0);
        ack_force = 1'b1;
        bus.d_req = 1'b0;
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
        @(negedge clk);
        check_eq("t5_post_state", dbg_state, S_IDLE);
        check_eq("t5_post_done", {bus.if_done, bus.d_done}, 0);
        cyc();
        ack_force  = 1'b0;
        fixed_wait = 0;
        @(negedge clk);
        check_eq("t5_post_d_rdata", bus.d_rdata, 0);
        check_eq("t5_post_state2", dbg_state, S_IDLE);

        // spurious ack while idle
        saved = bus.if_rdata;
        cyc();
        ack_force = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("t6_state", dbg_state, S_IDLE);
            check_eq("t6_done", {bus.if_done, bus.d_done}, 0);
            check_eq("t6_mem_req", bus.mem_req, 0);
            check_eq("t6_if_rdata", bus.if_rdata, saved);
            cyc();
        end
        ack_force = 1'b0;

        // random traffic with random wait states
        cyc();
        fixed_wait = -1;
        fork
            if_agent(30);
            d_agent(30);
        join
        repeat (4) cyc();
        @(negedge clk);
        check_eq("final_idle", dbg_state, S_IDLE);
        check_eq("final_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates a single-port unified instruction/data memory between the pipeline's instruction-fetch (IF) requester and the load/store (MEM) requester. It sequences every memory transaction through a req/ack handshake and returns read data to the winning requester. It also drives a pipeline-freeze signal that holds the whole pipeline while any access is outstanding. It sits between the datapath's IF/MEM stages and the memory model, alongside the hazard and forwarding logic.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_MAX, 4, max consecutive data grants while IF waits (≥1)

- clk  in  1  clock, rising-edge
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request, held until if_done
- if_addr  in  ADDR_W  fetch address
- if_done  out  1  one-cycle pulse, fetch complete
- if_rdata  out  DATA_W  registered fetched word
- d_req  in  1  data request, held until d_done
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_done  out  1  one-cycle pulse, data access complete
- d_rdata  out  DATA_W  registered load word
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_ack  in  1  memory completion; mem_rdata valid in the same cycle
- mem_rdata  in  DATA_W  memory read data
- pipe_stall  out  1  freeze pipeline registers and PC

## Operation
- FSM states:
  - IDLE: arbitrate.
  - GNT_I: fetch in flight.
  - GNT_D: data access in flight.
  - RESP: done pulse.
- IDLE transitions:
  - d_req only → GNT_D.
  - if_req only → GNT_I.
  - Both requesting → GNT_D, unless starve_cnt == STARVE_MAX, then GNT_I.
  - Neither requesting → stay in IDLE.
- On the IDLE→GNT_x edge: latch the winner's addr, we and wdata into mem_addr/mem_we/mem_wdata. Fetches always have mem_we = 0. Requester inputs are ignored after latching.
- GNT_x: mem_req = 1 with stable outputs until mem_ack is sampled high; then → RESP.
  - At that edge, a read captures mem_rdata into if_rdata or d_rdata.
  - A store leaves d_rdata unchanged.
- RESP: mem_req = 0, mem_we = 0, and exactly one of if_done/d_done = 1. Requests are not sampled. Next state is IDLE.
- starve_cnt (width clog2(STARVE_MAX+1)):
  - Increments, saturating, on each data grant issued while if_req = 1.
  - Clears on an IF grant, or in any IDLE cycle with if_req = 0.
- pipe_stall = (if_req & ~if_done) | (d_req & ~d_done). It is combinational and forced to 0 while rst = 0.
- Reset (rst = 0, any time, including mid-transaction):
  - State → IDLE, starve_cnt → 0.
  - mem_req, mem_we, if_done, d_done → 0.
  - mem_addr, mem_wdata, if_rdata, d_rdata → 0.
  - Any in-flight memory transaction is abandoned; a late mem_ack is ignored outside GNT_x.
- mem_ack sampled high in IDLE or RESP: ignored.

## Timing
- Zero-wait memory (ack in the first mem_req cycle):
  - Request sampled in IDLE at cycle 0.
  - mem_req high in cycle 1.
  - done in cycle 2, with rdata already valid.
  - IDLE in cycle 3.
- Each access occupies at least 3 cycles. Each cycle of ack wait adds one cycle.
- if_rdata/d_rdata are valid from the done cycle and hold until the next read of the same port.
- All outputs except pipe_stall are registered.

## Test plan
- Single fetch, zero-wait: if_req = 1, if_addr = 0x10, mem_rdata = 0x8C010004, mem_ack = 1.
  - mem_req = 1, mem_addr = 0x10, mem_we = 0 in cycle 1.
  - if_done = 1 in cycle 2, with if_rdata = 0x8C010004.
  - pipe_stall = 1 in cycles 0–1 and 0 in cycle 2.
- Simultaneous requests: if_req at 0x10 and a load at d_addr = 0x100, both in cycle 0.
  - mem_addr = 0x100 first; d_done in cycle 2.
  - Then mem_addr = 0x10 in cycle 4; if_done in cycle 5.
- Store with wait states: d_we = 1, d_addr = 0x20, d_wdata = 0xDEADBEEF, mem_ack first high in the 4th mem_req cycle. Change d_addr after the grant.
  - mem_req is held for 4 cycles with mem_addr = 0x20, mem_wdata = 0xDEADBEEF and mem_we = 1, all stable.
  - d_done follows one cycle after the ack cycle.
  - d_rdata is unchanged.
- Starvation guard, STARVE_MAX = 4: d_req and if_req held continuously, zero-wait memory.
  - Grants go data ×4, then IF, then data again.
  - starve_cnt reads 0 after the IF grant.
- Reset mid-access: pull rst low during GNT_D while mem_req = 1, then assert mem_ack during reset and one cycle after release.
  - All outputs go to 0 immediately (asynchronous).
  - After release the FSM is in IDLE; no done pulse and no rdata update occur.
- Late/spurious ack: mem_ack = 1 in IDLE with no requests.
  - No state change, no done pulse, outputs unchanged.
